// File: rtl/spi_byte_tx_if.sv
// spi_byte_tx_if: byte handshake and SPI pins between the display Controller and spi_byte_tx.
//  dataRdy/data are driven by the Controller (master).
//  transEna/busy/sclk/mosi/cs_n are driven by the transmitter (slave).
interface spi_byte_tx_if;
  logic       dataRdy;
  logic [7:0] data;
  logic       transEna;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  modport master (output dataRdy, data, input transEna, busy, sclk, mosi, cs_n);
  modport slave  (input dataRdy, data, output transEna, busy, sclk, mosi, cs_n);
endinterface

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-0 write-only SPI byte transmitter; ports clk, reset (sync, active-high), bus (spi_byte_tx_if.slave: dataRdy/data in, transEna/busy/sclk/mosi/cs_n out); SPI_TX_LSB_FIRST_EN selects LSB-first bit order.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input logic           clk,
  input logic           reset,
  spi_byte_tx_if.slave  bus
);
`ifdef SPI_TX_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
  state_t     state;
  logic [7:0] shreg, sh_nx, div_cnt;
  logic [3:0] bitcnt;
  logic       div_end;
  assign sh_nx   = LSB_FIRST ? shreg >> 1 : shreg << 1;
  assign div_end = div_cnt == 8'd0;
  // The next bit is presented as sclk falls, giving it a full low phase of setup before the next rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= 8'd0;
      div_cnt      <= 8'd0;
      bitcnt       <= 4'd0;
      bus.sclk     <= 1'b0;
      bus.mosi     <= 1'b0;
      bus.cs_n     <= 1'b1;
      bus.transEna <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      if (state == SETUP || state == HIGH || state == LOW)
        div_cnt <= div_end ? DIV_LAST : div_cnt - 8'd1;
      case (state)
        IDLE: if (bus.dataRdy) begin
          state    <= SETUP;
          shreg    <= bus.data;
          bitcnt   <= 4'd0;
          div_cnt  <= DIV_LAST;
          bus.cs_n <= 1'b0;
          bus.busy <= 1'b1;
          bus.mosi <= LSB_FIRST ? bus.data[0] : bus.data[7];
        end
        SETUP: if (div_end) begin
          state    <= HIGH;
          bus.sclk <= 1'b1;
        end
        HIGH: if (div_end) begin
          state    <= LOW;
          bus.sclk <= 1'b0;
          shreg    <= sh_nx;
          bus.mosi <= LSB_FIRST ? sh_nx[0] : sh_nx[7];
          bitcnt   <= bitcnt + 4'd1;
        end
        LOW: if (div_end) begin
          if (bitcnt == 4'd8) begin
            state        <= DONE;
            bus.cs_n     <= 1'b1;
            bus.transEna <= 1'b1;
          end else begin
            state    <= HIGH;
            bus.sclk <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.transEna <= 1'b0;
          bus.busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: scoreboard bench for spi_byte_tx at CLK_DIV=4 (inst 0) and CLK_DIV=1 (inst 1).
module tb_spi_byte_tx;
  localparam int D0 = 4;
  localparam int D1 = 1;
`ifdef SPI_TX_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_q;
  always #5 clk = ~clk;
  spi_byte_tx_if if0 ();
  spi_byte_tx_if if1 ();
  spi_byte_tx #(.CLK_DIV(D0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  spi_byte_tx #(.CLK_DIV(D1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int checks = 0;
  int errors = 0;
  int done_cnt[2];
  logic [1:0] sclk_v, mosi_v, cs_v, te_v, busy_v;
  assign sclk_v = {if1.sclk, if0.sclk};
  assign mosi_v = {if1.mosi, if0.mosi};
  assign cs_v   = {if1.cs_n, if0.cs_n};
  assign te_v   = {if1.transEna, if0.transEna};
  assign busy_v = {if1.busy, if0.busy};
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction
  always @(posedge clk) rst_q <= reset;
  // Monitor: reconstructs each frame from the pins and checks it against the queued byte.
  logic       in_frame[2];
  int         low_len[2], nbits[2], stable[2];
  logic [7:0] bits[2];
  logic       prev_cs[2], prev_sclk[2], prev_mosi[2], prev_te[2];
  logic       start;
  int         d;
  logic [7:0] exp_b, want;
  initial for (int i = 0; i < 2; i++) begin
    done_cnt[i] = 0; in_frame[i] = 1'b0; prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0;
    prev_mosi[i] = 1'b0; prev_te[i] = 1'b0; low_len[i] = 0; nbits[i] = 0; stable[i] = 0; bits[i] = 8'd0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? D0 : D1;
      if (rst_q) begin
        checks++;
        if ({cs_v[i], sclk_v[i], te_v[i], busy_v[i], mosi_v[i]} != 5'b10000) begin
          errors++;
          $display("FAIL reset_values inst%0d cs_n,sclk,transEna,busy,mosi got %b want 10000", i,
                   {cs_v[i], sclk_v[i], te_v[i], busy_v[i], mosi_v[i]});
        end
        in_frame[i] = 1'b0;
      end else begin
        start = prev_cs[i] && !cs_v[i];
        if (start) begin
          in_frame[i] = 1'b1; low_len[i] = 0; nbits[i] = 0; bits[i] = 8'd0;
          checks++;
          if (!busy_v[i]) begin errors++; $display("FAIL busy_start inst%0d got %b want 1", i, busy_v[i]); end
        end
        if (in_frame[i] && !cs_v[i]) begin
          low_len[i]++;
          if (!start && mosi_v[i] != prev_mosi[i] && sclk_v[i]) begin
            checks++; errors++;
            $display("FAIL mosi_stable inst%0d mosi changed to %b while sclk high, want no change", i, mosi_v[i]);
          end
          stable[i] = (start || mosi_v[i] != prev_mosi[i]) ? 1 : stable[i] + 1;
          if (sclk_v[i] && !prev_sclk[i]) begin
            checks++;
            if (stable[i] <= d) begin
              errors++;
              $display("FAIL mosi_setup inst%0d held %0d cycles before rise, want >= %0d", i, stable[i] - 1, d);
            end
            bits[i] = {bits[i][6:0], mosi_v[i]};
            nbits[i]++;
          end
        end
        if ((in_frame[i] && cs_v[i] && !prev_cs[i]) || te_v[i]) begin
          checks++;
          if (!(te_v[i] && busy_v[i] && in_frame[i] && cs_v[i] && !prev_cs[i] && !prev_te[i])) begin
            errors++;
            $display("FAIL done_cycle inst%0d transEna,busy,in_frame,cs_rose,prev_te got %b%b%b%b%b want 11110", i,
                     te_v[i], busy_v[i], in_frame[i], cs_v[i] && !prev_cs[i], prev_te[i]);
          end
          checks++;
          if (low_len[i] != 17 * d) begin
            errors++; $display("FAIL frame_len inst%0d got %0d want %0d", i, low_len[i], 17 * d);
          end
          checks++;
          if (nbits[i] != 8) begin
            errors++; $display("FAIL rise_count inst%0d got %0d want 8", i, nbits[i]);
          end
          checks++;
          if (((i == 0) ? q0.size() : q1.size()) == 0) begin
            errors++; $display("FAIL unexpected_byte inst%0d got bits %h want no frame", i, bits[i]);
          end else begin
            exp_b = (i == 0) ? q0.pop_front() : q1.pop_front();
            want = LSB ? rev8(exp_b) : exp_b;
            if (bits[i] != want) begin
              errors++;
              $display("FAIL byte inst%0d got serial %h want %h (byte %h)", i, bits[i], want, exp_b);
            end
          end
          in_frame[i] = 1'b0;
          done_cnt[i]++;
        end
      end
      prev_cs[i] = cs_v[i]; prev_sclk[i] = sclk_v[i]; prev_mosi[i] = mosi_v[i]; prev_te[i] = te_v[i];
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int i, input logic [7:0] b);
    if (i == 0) begin if0.dataRdy = 1'b1; if0.data = b; q0.push_back(b); end
    else begin if1.dataRdy = 1'b1; if1.data = b; q1.push_back(b); end
    tick;
    if (i == 0) begin if0.dataRdy = 1'b0; if0.data = 8'($urandom); end
    else begin if1.dataRdy = 1'b0; if1.data = 8'($urandom); end
  endtask
  task automatic wait_done(input int i, input int n);
    for (int k = 0; k < 3000 && done_cnt[i] < n; k++) tick;
    if (done_cnt[i] < n) begin
      $display("FAIL wait_done inst%0d frames got %0d want %0d", i, done_cnt[i], n);
      $fatal(1, "frame timeout");
    end
  endtask
  initial begin
    int n0;
    if0.dataRdy = 1'b0; if0.data = 8'h00;
    if1.dataRdy = 1'b0; if1.data = 8'h00;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    send(0, 8'hA5); wait_done(0, 1);
    send(0, 8'h00); wait_done(0, 2);
    send(0, 8'hFF); wait_done(0, 3);
    send(0, 8'h01); wait_done(0, 4);
    n0 = 4;
    for (int k = 0; k < 4; k++) begin
      send(0, 8'($urandom)); n0++; wait_done(0, n0);
    end
    for (int n = 0; n < 141; n++) begin
      if0.dataRdy = 1'b1;
      if0.data = 8'($urandom);
      if (n % (17 * D0 + 2) == 0) q0.push_back(if0.data);
      tick;
    end
    if0.dataRdy = 1'b0;
    n0 += 3; wait_done(0, n0);
    tick;
    send(0, 8'($urandom));
    repeat (29) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    void'(q0.pop_back());
    repeat (80) tick;
    send(0, 8'h3C); n0++; wait_done(0, n0);
    send(1, 8'h81); wait_done(1, 1);
    for (int k = 0; k < 3; k++) begin
      send(1, 8'($urandom)); wait_done(1, k + 2);
    end
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
